// File: rtl/mux_arbiter2.sv
// mux_arbiter2: round-robin arbiter for two requesters sharing one multi-cycle unit,
// presenting the winner's operand through a registered mux.
module mux_arbiter2 #(
    parameter int N   = 9,
    parameter int LAT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [N-1:0] in0,
    input  logic         req1,
    input  logic [N-1:0] in1,
    input  logic         out_ready,
    output logic         gnt0,
    output logic         gnt1,
    output logic         sel,
    output logic [N-1:0] mux_out,
    output logic         out_valid,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         ptr_q, ptr_d;
    logic         sel_q, sel_d;
    logic         gnt0_q, gnt0_d;
    logic         gnt1_q, gnt1_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic [N-1:0] mux_q, mux_d;
    logic         win;

    always_comb begin
        win     = (req0 && req1) ? ptr_q : req1;
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        mux_d   = mux_q;
        valid_d = valid_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        case (state_q)
            IDLE: if (req0 || req1) begin
                state_d = ISSUE;
                sel_d   = win;
                mux_d   = win ? in1 : in0;
                gnt0_d  = !win;
                gnt1_d  = win;
                valid_d = 1'b1;
                ptr_d   = !win;
            end
            ISSUE: if (out_ready) begin
                valid_d = 1'b0;
                state_d = (LAT == 1) ? IDLE : HOLD;
                cnt_d   = 4'(LAT - 1);
            end
            HOLD: begin
                cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                state_d = (cnt_q <= 4'd1) ? IDLE : HOLD;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ptr_q   <= 1'b0;
            sel_q   <= 1'b0;
            mux_q   <= '0;
            valid_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            mux_q   <= mux_d;
            valid_q <= valid_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign sel       = sel_q;
    assign mux_out   = mux_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
endmodule

// File: doc/mux_arbiter2.md
MUX_ARBITER2 -- requirements
Module: mux_arbiter2

Interface
REQ-001 SHALL provide parameter N, default 9: operand width in bits.
REQ-002 SHALL provide parameter LAT, default 3: shared-unit occupancy per operation in cycles, legal range 1..15.
REQ-003 SHALL provide port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1: reset; asynchronous, active-low.
REQ-005 SHALL provide port req0, input, 1: requester 0 wants the shared unit.
REQ-006 SHALL provide port in0, input, N: requester 0 operand.
REQ-007 SHALL provide port req1, input, 1: requester 1 wants the shared unit.
REQ-008 SHALL provide port in1, input, N: requester 1 operand.
REQ-009 SHALL provide port out_ready, input, 1: shared unit accepts the presented operand.
REQ-010 SHALL provide port gnt0, output, 1: one-cycle pulse, requester 0 operand captured.
REQ-011 SHALL provide port gnt1, output, 1: one-cycle pulse, requester 1 operand captured.
REQ-012 SHALL provide port sel, output, 1: registered select of the last granted requester (0 = in0, 1 = in1).
REQ-013 SHALL provide port mux_out, output, N: registered operand presented to the shared unit.
REQ-014 SHALL provide port out_valid, output, 1: mux_out holds a valid operand.
REQ-015 SHALL provide port busy, output, 1: shared unit is occupied (states ISSUE or HOLD).

Function
REQ-016 SHALL implement three states: IDLE, ISSUE, HOLD.
REQ-017 SHALL, in IDLE, sample req0/req1 at the clock edge; if neither is high, stay in IDLE.
REQ-018 SHALL pick the only requester when exactly one req is high.
REQ-019 SHALL, when both reqs are high, pick the requester not granted most recently (round-robin pointer); after reset the pointer favours requester 0.
REQ-020 SHALL, on the winning edge, register mux_out <= winner operand, sel <= winner index, set the winner's gnt high for exactly one cycle, set out_valid=1, move to ISSUE, and point the round-robin pointer at the other requester.
REQ-021 SHALL, in ISSUE, hold mux_out, sel and out_valid stable until out_ready is sampled high.
REQ-022 SHALL, on the ISSUE edge where out_ready=1, clear out_valid, then go to IDLE if LAT=1, else go to HOLD with a down-counter loaded to LAT-1.
REQ-023 SHALL, in HOLD, decrement the counter each cycle and return to IDLE on the edge where the counter reaches 0; HOLD lasts exactly LAT-1 cycles.
REQ-024 SHALL ignore reqs in ISSUE and HOLD; requesters hold req and data until their gnt, and a req dropped before grant receives no grant.
REQ-025 SHALL give back-to-back throughput, with out_ready constantly high, of one grant per LAT+1 cycles.
REQ-026 SHALL keep mux_out and sel at their last values in IDLE and HOLD (out_valid=0 there); sel never changes except on a grant edge.
REQ-027 SHALL keep gnt0 and gnt1 mutually exclusive and never assert either outside the cycle following a grant edge.

Reset
REQ-028 SHALL, while rst_n=0, immediately force: state IDLE, gnt0=0, gnt1=0, sel=0, mux_out=0, out_valid=0, busy=0, counter=0, pointer favouring requester 0.
REQ-029 SHALL, on reset asserted mid-operation (ISSUE or HOLD), abandon the pending operation with no further gnt or out_valid; after rst_n rises, the first edge is evaluated as IDLE.

Verification
REQ-030 SHALL verify single request: N=9, LAT=3, req0=1, in0=9'h001, out_ready=1 -> gnt0 for one cycle, mux_out=9'h001, sel=0, out_valid for one cycle, busy for 3 cycles, then IDLE.
REQ-031 SHALL verify fairness: req0=req1=1 held continuously, in0=9'h155, in1=9'h0AA -> grants alternate 0,1,0,1 starting with 0, one grant every 4 cycles, mux_out alternates 9'h155 / 9'h0AA.
REQ-032 SHALL verify backpressure: out_ready=0 for 5 cycles after a grant of in1=9'h1FF -> out_valid, mux_out=9'h1FF and sel=1 stay stable for all 5 cycles; out_valid drops on the first edge with out_ready=1.
REQ-033 SHALL verify LAT=1: continuous req1 with out_ready=1 -> a grant every 2 cycles and no HOLD cycle.
REQ-034 SHALL verify reset mid-op: rst_n pulled low during HOLD -> all outputs 0 asynchronously, without waiting for a clock edge; after release with req1=1 only, gnt1 occurs on the first edge.
REQ-035 SHALL verify ignored request: req0 raised during HOLD and dropped before IDLE -> no gnt0 is ever issued.
